// File: rtl/dice_button_arbiter.sv
// dice_button_arbiter: synchronise, debounce and arbitrate buttons into one locked owner; LONG_PRESS_EN builds the long_press hold counter
module dice_button_arbiter #(
  parameter int NBTN       = 7,
  parameter int DEB_TICKS  = 3,
  parameter int LONG_TICKS = 32
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_held,
  output logic            any_held,
  output logic            press,
  output logic            release_pulse,
  output logic            long_press
);
  localparam int CW = $clog2(DEB_TICKS + 1);
  typedef enum logic [1:0] {IDLE, LOCKED, DRAIN} state_t;
  state_t          state, state_n;
  logic [NBTN-1:0] s1, sync, stab, held_n;
  logic [CW-1:0]   cnt [NBTN];
  logic            press_n, rel_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      sync <= '0;
      stab <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn_raw;
      sync <= s1;
      if (tick)
        for (int i = 0; i < NBTN; i++) begin
          cnt[i]  <= (sync[i] != stab[i] && cnt[i] != CW'(DEB_TICKS - 1)) ? cnt[i] + 1'b1 : '0;
          stab[i] <= (sync[i] != stab[i] && cnt[i] == CW'(DEB_TICKS - 1)) ? ~stab[i] : stab[i];
        end
    end
  end
  always_comb begin
    state_n = state;
    held_n  = btn_held;
    press_n = 1'b0;
    rel_n   = 1'b0;
    if (state == IDLE && |stab) begin
      state_n = LOCKED;
      held_n  = stab & (~stab + 1'b1);
      press_n = 1'b1;
    end else if (state == LOCKED && !(|(stab & btn_held))) begin
      state_n = DRAIN;
      held_n  = '0;
      rel_n   = 1'b1;
    end else if (state == DRAIN && !(|stab)) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      btn_held      <= '0;
      any_held      <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      btn_held      <= held_n;
      any_held      <= |held_n;
      press         <= press_n;
      release_pulse <= rel_n;
    end
  end
`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  logic [HW-1:0] hcnt, hcnt_n;
  logic          long_n;
  always_comb begin
    hcnt_n = (state == IDLE) ? '0 :
             (state == LOCKED && tick && hcnt != HW'(LONG_TICKS)) ? hcnt + 1'b1 : hcnt;
    long_n = !rel_n && ((state == LOCKED && hcnt_n == HW'(LONG_TICKS)) || long_press);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      hcnt       <= hcnt_n;
      long_press <= long_n;
    end
  end
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_dice_button_arbiter.sv
// tb_dice_button_arbiter: table, directed and random checks of dice_button_arbiter against a behavioural model
module tb_dice_button_arbiter;
  localparam int NBTN = 7;
  localparam int DEB  = 3;
  localparam int LT   = 4;
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif
  logic            clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic [NBTN-1:0] btn_raw = '0;
  logic [NBTN-1:0] btn_held;
  logic            any_held, press, release_pulse, long_press;
  dice_button_arbiter #(.NBTN(NBTN), .DEB_TICKS(DEB), .LONG_TICKS(LT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_raw(btn_raw),
    .btn_held(btn_held), .any_held(any_held), .press(press),
    .release_pulse(release_pulse), .long_press(long_press)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0, n_press = 0, n_rel = 0, n = 0;
  logic [NBTN-1:0] d1, d2, stable_m;
  int   run [NBTN];
  int   mode = 0, owner = -1, hold = 0;
  logic p_m = 1'b0, r_m = 1'b0, l_m = 1'b0;
  typedef struct {
    logic [NBTN-1:0] raw;
    int              clks;
    logic [NBTN-1:0] exp_held;
    int              exp_press;
    int              exp_rel;
    logic            exp_long;
  } vec_t;
  vec_t tbl [10];
  function automatic logic [NBTN-1:0] held_m();
    return owner < 0 ? '0 : NBTN'(1 << owner);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  // Model: mode 0 = no owner, 1 = owner held, 2 = waiting for all buttons up
  task automatic model_step();
    if (rst) begin
      d1 = '0; d2 = '0; stable_m = '0;
      for (int i = 0; i < NBTN; i++) run[i] = 0;
      mode = 0; owner = -1; hold = 0; p_m = 0; r_m = 0; l_m = 0;
      return;
    end
    p_m = 0; r_m = 0;
    if (mode == 0) begin
      if (stable_m != 0) begin
        for (int i = NBTN - 1; i >= 0; i--) if (stable_m[i]) owner = i;
        p_m = 1; hold = 0; mode = 1;
      end
    end else if (mode == 1) begin
      if (!stable_m[owner]) begin
        owner = -1; r_m = 1; l_m = 0; mode = 2;
      end else if (tick) begin
        if (hold < LT) hold++;
        if (LONG_ON && hold == LT) l_m = 1;
      end
    end else if (stable_m == 0) begin
      mode = 0;
    end
    if (tick)
      for (int i = 0; i < NBTN; i++)
        if (d2[i] != stable_m[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            stable_m[i] = ~stable_m[i];
            run[i] = 0;
          end
        end else run[i] = 0;
    d2 = d1;
    d1 = btn_raw;
  endtask
  task automatic cycle();
    @(negedge clk);
    tick = (cyc % 4 == 3);
    cyc++;
    @(posedge clk);
    model_step();
    #1;
    n_press += int'(press);
    n_rel   += int'(release_pulse);
    check("outputs", {btn_held, any_held, press, release_pulse, long_press},
          {held_m(), owner >= 0, p_m, r_m, l_m});
    check("press_release_exclusive", press & release_pulse, 0);
  endtask
  task automatic wait_press(output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (!press && cnt < 40);
  endtask
  initial begin
    tbl = '{
      '{7'h04,  8, 7'h00, 0, 0, 1'b0},
      '{7'h00, 24, 7'h00, 0, 0, 1'b0},
      '{7'h08, 24, 7'h08, 1, 0, 1'b0},
      '{7'h0A, 24, 7'h08, 0, 0, 1'b0},
      '{7'h02, 24, 7'h00, 0, 1, 1'b0},
      '{7'h00, 24, 7'h00, 0, 0, 1'b0},
      '{7'h30, 24, 7'h10, 1, 0, 1'b0},
      '{7'h00, 24, 7'h00, 0, 1, 1'b0},
      '{7'h01, 40, 7'h01, 1, 0, LONG_ON},
      '{7'h00, 24, 7'h00, 0, 1, 1'b0}
    };
    rst = 1'b1;
    btn_raw = 7'h7F;
    cycle();
    rst = 1'b0;
    check("reset_outputs", {btn_held, any_held, press, release_pulse, long_press}, 0);
    wait_press(n);
    check_range("reset_repress_latency", n, 12, 15);
    check("reset_repress_held", btn_held, 7'h01);
    btn_raw = '0;
    repeat (24) cycle();
    foreach (tbl[k]) begin
      btn_raw = tbl[k].raw;
      n_press = 0;
      n_rel = 0;
      repeat (tbl[k].clks) cycle();
      check($sformatf("vec%0d_held", k), btn_held, tbl[k].exp_held);
      check($sformatf("vec%0d_any", k), any_held, tbl[k].exp_held != 0);
      check($sformatf("vec%0d_press", k), n_press, tbl[k].exp_press);
      check($sformatf("vec%0d_release", k), n_rel, tbl[k].exp_rel);
      check($sformatf("vec%0d_long", k), long_press, tbl[k].exp_long);
    end
    btn_raw = 7'h40;
    wait_press(n);
    check("midreset_first_held", btn_held, 7'h40);
    repeat (8) cycle();
    n_rel = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midreset_outputs", {btn_held, any_held, press, release_pulse, long_press}, 0);
    wait_press(n);
    check_range("midreset_repress_latency", n, 12, 15);
    check("midreset_repress_held", btn_held, 7'h40);
    check("midreset_no_release", n_rel, 0);
    btn_raw = '0;
    repeat (24) cycle();
    repeat (60) begin
      btn_raw = NBTN'($urandom);
      rst = ($urandom_range(0, 9) == 0);
      cycle();
      rst = 1'b0;
      repeat ($urandom_range(1, 30)) cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
